// File: rtl/nfp_pkg.sv
// Shared widths and types for the noise-free-pixel accumulator and the mean stage.
package nfp_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned SUM_W = 11;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WIN_N = 9;
  localparam int unsigned IDX_W = 4;

  localparam logic [IDX_W-1:0] IDX_CTR  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN_N - 1);

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    pix_t             ctr_pix;
    logic             ctr_noisy;
  } nfp_bundle_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/nfp_accum_noise_det.sv
// Salt-and-pepper classifier: flags a pixel equal to either extreme noise value.
module noise_det
  import nfp_pkg::*;
#(
  parameter pix_t NOISE_LO = 8'd0,
  parameter pix_t NOISE_HI = 8'd255
) (
  input  pix_t pix,
  output logic noisy_c
);

  assign noisy_c = (pix == NOISE_LO) || (pix == NOISE_HI);

endmodule

// File: rtl/nfp_accum.sv
// Window front-end: serial 3x3 window in, sum/count of clean neighbours plus
// centre pixel and its noise flag out, with a single-entry output slot.
module nfp_accum
  import nfp_pkg::*;
#(
  parameter pix_t NOISE_LO = 8'd0,
  parameter pix_t NOISE_HI = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [SUM_W-1:0] nfp_sum,
  output logic [CNT_W-1:0] nfp_cnt,
  output logic [PIX_W-1:0] ctr_pix,
  output logic             ctr_noisy,
  output logic             out_valid,
  input  logic             out_ready
);

  slot_state_e      state_q;
  slot_state_e      state_nxt_c;
  logic [IDX_W-1:0] idx_q;
  logic [SUM_W-1:0] sum_acc;
  logic [CNT_W-1:0] cnt_acc;
  pix_t             ctr_pix_acc;
  logic             ctr_noisy_acc;
  nfp_bundle_t      out_q;

  logic             pix_noisy_c;
  logic             accept_c;
  logic             last_c;
  logic             load_c;
  logic [SUM_W-1:0] sum_add_c;
  logic [CNT_W-1:0] cnt_add_c;

  noise_det #(
    .NOISE_LO (NOISE_LO),
    .NOISE_HI (NOISE_HI)
  ) u_noise_det (
    .pix     (pix_in),
    .noisy_c (pix_noisy_c)
  );

  // Stall only when the closing pixel would overwrite an unconsumed bundle.
  assign last_c    = (idx_q == IDX_LAST);
  assign pix_ready = !(last_c && out_valid && !out_ready);
  assign accept_c  = pix_valid && pix_ready;

  // Running totals including the current pixel when it is clean.
  always_comb begin
    sum_add_c = sum_acc;
    cnt_add_c = cnt_acc;
    if (!pix_noisy_c) begin
      sum_add_c = sum_acc + SUM_W'(pix_in);
      cnt_add_c = cnt_acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= IDX_CTR;
    end else if (accept_c) begin
      idx_q <= last_c ? IDX_CTR : idx_q + IDX_W'(1);
    end
  end

  // Centre pixel opens a window and is excluded from the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_acc       <= '0;
      cnt_acc       <= '0;
      ctr_pix_acc   <= '0;
      ctr_noisy_acc <= 1'b0;
    end else if (accept_c) begin
      if (idx_q == IDX_CTR) begin
        sum_acc       <= '0;
        cnt_acc       <= '0;
        ctr_pix_acc   <= pix_in;
        ctr_noisy_acc <= pix_noisy_c;
      end else begin
        sum_acc <= sum_add_c;
        cnt_acc <= cnt_add_c;
      end
    end
  end

  // Output slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  // Output slot next state; a closing accept refills the slot even while draining.
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept_c && last_c) state_nxt_c = SLOT_FULL;
      SLOT_FULL: begin
        if (accept_c && last_c) state_nxt_c = SLOT_FULL;
        else if (out_ready)     state_nxt_c = SLOT_EMPTY;
      end
      default: state_nxt_c = SLOT_EMPTY;
    endcase
  end

  // Output slot decode.
  always_comb begin
    load_c = 1'b0;
    if (accept_c && last_c) load_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (load_c) begin
      out_q <= '{sum: sum_add_c, cnt: cnt_add_c,
                 ctr_pix: ctr_pix_acc, ctr_noisy: ctr_noisy_acc};
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign nfp_sum   = out_q.sum;
  assign nfp_cnt   = out_q.cnt;
  assign ctr_pix   = out_q.ctr_pix;
  assign ctr_noisy = out_q.ctr_noisy;

endmodule

// File: tb/tb_nfp_accum.sv
// Directed bench for nfp_accum: hand-computed windows, backpressure, coincident
// handshake and mid-window reset.
module tb_nfp_accum;

  logic        clk;
  logic        rst;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] nfp_sum;
  logic [3:0]  nfp_cnt;
  logic [7:0]  ctr_pix;
  logic        ctr_noisy;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;
  logic [7:0] win [9];

  nfp_accum dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .nfp_sum   (nfp_sum),
    .nfp_cnt   (nfp_cnt),
    .ctr_pix   (ctr_pix),
    .ctr_noisy (ctr_noisy),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int sum, input int cnt,
                         input int cp, input int cn);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"},   32'(nfp_sum),   32'(sum));
    chk({tag, ".cnt"},   32'(nfp_cnt),   32'(cnt));
    chk({tag, ".ctr"},   32'(ctr_pix),   32'(cp));
    chk({tag, ".noisy"}, 32'(ctr_noisy), 32'(cn));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, 32'(pix_ready), 32'd1);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".sum"},   32'(nfp_sum),   32'd0);
    chk({tag, ".cnt"},   32'(nfp_cnt),   32'd0);
    chk({tag, ".ctr"},   32'(ctr_pix),   32'd0);
    chk({tag, ".noisy"}, 32'(ctr_noisy), 32'd0);
  endtask

  // Present one pixel at posedge+1, wait (bounded) for ready, accept on the edge.
  task automatic send_pix(input logic [7:0] p);
    int waits;
    pix_in    = p;
    pix_valid = 1'b1;
    waits     = 0;
    while (!pix_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!pix_ready) chk("send_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_pix(win[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    pix_in    = 8'd0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    idle(1);

    // Clean neighbours, noisy centre; valid exactly one cycle after the 9th accept.
    win = '{8'd255, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    send_range(0, 7);
    chk("clean.pre_valid", 32'(out_valid), 32'd0);
    send_range(8, 8);
    chk_out("clean", 360, 8, 255, 1);
    idle(1);
    chk("clean.drained", 32'(out_valid), 32'd0);

    win = '{8'd100, 8'd0, 8'd255, 8'd7, 8'd0, 8'd9, 8'd255, 8'd11, 8'd255};
    send_range(0, 8);
    chk_out("mixed", 27, 3, 100, 0);

    win = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
    send_range(0, 8);
    chk_out("allnoise", 0, 0, 0, 1);

    win = '{8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254};
    send_range(0, 8);
    chk_out("max", 2032, 8, 254, 0);
    idle(1);
    chk("max.drained", 32'(out_valid), 32'd0);

    // Backpressure: second window stalls at its closing pixel.
    out_ready = 1'b0;
    win = '{8'd5, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_range(0, 8);
    chk_out("bp.a", 36, 8, 5, 0);
    win = '{8'd6, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16};
    send_range(0, 7);
    pix_in    = win[8];
    pix_valid = 1'b1;
    #1;
    chk("bp.stall", 32'(pix_ready), 32'd0);
    idle(3);
    chk("bp.still_stalled", 32'(pix_ready), 32'd0);
    chk_out("bp.a_held", 36, 8, 5, 0);
    out_ready = 1'b1;
    #1;
    chk("bp.release", 32'(pix_ready), 32'd1);
    chk("bp.a_taken", 32'(nfp_sum), 32'd36);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk_out("bp.b", 72, 8, 6, 0);
    idle(1);
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Coincident handshake and closing accept: slot stays full, no stall.
    out_ready = 1'b0;
    win = '{8'd9, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
    send_range(0, 8);
    chk_out("coin.c", 80, 8, 9, 0);
    win = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd255, 8'd3, 8'd0, 8'd4, 8'd255};
    send_range(0, 7);
    chk_out("coin.c_held", 80, 8, 9, 0);
    out_ready = 1'b1;
    pix_in    = win[8];
    pix_valid = 1'b1;
    #1;
    chk("coin.no_stall", 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk_out("coin.d", 10, 4, 0, 1);
    idle(1);
    chk("coin.drained", 32'(out_valid), 32'd0);

    // Reset at idx 4 with a bundle pending, then a fresh window.
    out_ready = 1'b0;
    win = '{8'd50, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    send_range(0, 8);
    chk_out("rst.e", 800, 8, 50, 0);
    win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send_range(0, 3);
    rst = 1'b1;
    #2;
    chk_reset_vals("midrst");
    rst = 1'b0;
    idle(1);
    out_ready = 1'b1;
    win = '{8'd77, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_range(0, 8);
    chk_out("rst.fresh", 36, 8, 77, 0);
    idle(1);
    chk("rst.drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
